// File: rtl/ram_ctrl.sv
// Burst controller for the single-port word RAM bus: takes valid/ready read/write
// requests, drives the RAM strobes beat by beat and streams data in and out.
module ram_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_cs,
    output logic              ram_rd,
    output logic              ram_oe,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    // state | meaning
    // IDLE  | waiting for a request, req_ready high
    // WR    | write burst, one RAM write per accepted wr_valid beat
    // RD    | read burst, one RAM read per capture into rd_data
    // DONE  | burst finished, waiting for the last read beat to drain
    typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  beats_left;
    logic              is_write;
    logic              rd_cap;
    logic              exit_ok;

    // The output register can take a new beat if it is empty or being drained.
    assign rd_cap  = (state == RD) && (!rd_valid || rd_ready);
    assign exit_ok = is_write || !rd_valid || rd_ready;

    assign req_ready = (state == IDLE);
    assign wr_ready  = (state == WR);
    assign done      = (state == DONE) && exit_ok;

    // Strobes decode from state so they collapse as soon as reset forces IDLE.
    assign ram_cs    = ((state == WR) && wr_valid) || (state == RD);
    assign ram_rd    = (state != WR);
    assign ram_oe    = (state == RD);
    assign ram_addr  = cur_addr;
    assign ram_wdata = (state == WR) ? wr_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cur_addr   <= '0;
            beats_left <= '0;
            is_write   <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
        end else begin
            if (rd_cap) begin
                rd_valid <= 1'b1;
            end else if (rd_ready) begin
                rd_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cur_addr   <= req_addr;
                        beats_left <= req_len;
                        is_write   <= req_write;
                        state      <= req_write ? WR : RD;
                    end
                end
                WR: begin
                    if (wr_valid) begin
                        cur_addr   <= cur_addr + ADDR_W'(1);
                        beats_left <= beats_left - LEN_W'(1);
                        if (beats_left == '0) begin
                            state <= DONE;
                        end
                    end
                end
                RD: begin
                    if (rd_cap) begin
                        rd_data    <= ram_rdata;
                        cur_addr   <= cur_addr + ADDR_W'(1);
                        beats_left <= beats_left - LEN_W'(1);
                        if (beats_left == '0) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (exit_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl: behavioural RAM on the bus, a reference memory
// image and expected beat sequences computed from burst address/length arithmetic.
module tb_ram_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [3:0]  req_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        done;
    logic [7:0]  ram_addr;
    logic        ram_cs;
    logic        ram_rd;
    logic        ram_oe;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic [31:0] wdata   [16];
    logic [31:0] rd_q    [$];

    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;

    ram_ctrl #(.ADDR_W(8), .DATA_W(32), .LEN_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .done(done),
        .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_rd(ram_rd), .ram_oe(ram_oe),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM stores on the falling edge; the load port lets the bench preload contents.
    always @(negedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
        else if (ram_cs && !ram_rd) mem[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = (ram_cs && ram_oe && ram_rd) ? mem[ram_addr] : '0;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] v);
        load_en = 1; load_addr = a; load_data = v; ref_mem[a] = v;
        tick();
        load_en = 0;
    endtask

    task automatic issue(input logic w, input logic [7:0] a, input int n, output int ok);
        ok = 0;
        req_valid = 1; req_write = w; req_addr = a; req_len = 4'(n - 1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                ok = 1;
                tick();
                break;
            end
            tick();
        end
        req_valid = 0;
    endtask

    // Starts in the first WR cycle; mode 0 = wr_valid always, 1 = alternate, 2 = random.
    task automatic run_write(input logic [7:0] a, input int n, input int mode,
                             output int done_cyc, output int done_cnt, output int bad, output int last);
        int   beat;
        logic wv;
        beat = 0; done_cyc = 0; done_cnt = 0; bad = 0; last = 0;
        for (int c = 1; c <= 200; c++) begin
            if (beat >= n) wv = 0;
            else if (mode == 0) wv = 1;
            else if (mode == 1) wv = (c % 2 == 1);
            else wv = 1'($urandom_range(0, 1));
            wr_valid = wv;
            wr_data  = wv ? wdata[beat] : $urandom;
            @(negedge clk);
            if (ram_cs !== wv || ram_oe !== 1'b0) bad++;
            if (wv && (ram_rd !== 1'b0 || wr_ready !== 1'b1 || ram_addr !== 8'(a + beat)
                       || ram_wdata !== wdata[beat])) bad++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (wv) begin
                ref_mem[8'(a + beat)] = wdata[beat];
                beat++;
                last = c;
            end
            tick();
            if (done_cyc != 0) break;
        end
        wr_valid = 0;
    endtask

    // Starts in the first RD cycle; mode 0 = rd_ready always, 1 = pattern 1,0,0, 2 = random.
    task automatic run_read(input logic [7:0] a, input int n, input int mode,
                            output int done_cyc, output int done_cnt, output int bad, output int last);
        int   consumed;
        int   caps;
        logic rr;
        consumed = 0; done_cyc = 0; done_cnt = 0; bad = 0; last = 0;
        rd_q.delete();
        for (int c = 1; c <= 300; c++) begin
            if (mode == 0) rr = 1;
            else if (mode == 1) rr = ((c - 1) % 3 == 0);
            else rr = 1'($urandom_range(0, 1));
            rd_ready = rr;
            @(negedge clk);
            caps = consumed + (rd_valid ? 1 : 0);
            if (ram_oe !== logic'(caps < n)) bad++;
            if (caps < n && (ram_cs !== 1'b1 || ram_rd !== 1'b1 || ram_addr !== 8'(a + caps))) bad++;
            if (caps >= n && ram_cs !== 1'b0) bad++;
            if (rd_valid === 1'b1 && rr) begin
                rd_q.push_back(rd_data);
                consumed++;
                last = c;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
                if (consumed != n || !(rd_valid === 1'b1 && rr)) bad++;
            end
            tick();
            if (done_cyc != 0) break;
        end
        rd_ready = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({req_ready, wr_ready, rd_valid, done} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_handshake: got %b expected 1000", {req_ready, wr_ready, rd_valid, done});
        end
        checks++;
        if ({ram_cs, ram_rd, ram_oe} !== 3'b010) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 010", {ram_cs, ram_rd, ram_oe});
        end
        checks++;
        if (ram_addr !== 8'h00 || ram_wdata !== 32'h0 || rd_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: addr %h wdata %h rd_data %h expected all zero", ram_addr, ram_wdata, rd_data);
        end
        tick();
    endtask

    task automatic test_single();
        int ok, dc, dn, bad, last;
        wdata[0] = 32'hDEADBEEF;
        issue(1, 8'h10, 1, ok);
        run_write(8'h10, 1, 0, dc, dn, bad, last);
        checks++;
        if (ok != 1 || dc != 2 || dn != 1 || bad != 0) begin
            errors++;
            $display("FAIL single_write: ok %0d done_cyc %0d done_cnt %0d bad %0d expected 1 2 1 0", ok, dc, dn, bad);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || ram_cs !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: req_ready %b ram_cs %b expected 1 0", req_ready, ram_cs);
        end
        checks++;
        if (mem[8'h10] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_mem: got %h expected deadbeef", mem[8'h10]);
        end
        tick();
        issue(0, 8'h10, 1, ok);
        run_read(8'h10, 1, 0, dc, dn, bad, last);
        checks++;
        if (ok != 1 || rd_q.size() != 1 || dc != 2 || dn != 1 || bad != 0) begin
            errors++;
            $display("FAIL single_read: ok %0d beats %0d done_cyc %0d done_cnt %0d bad %0d expected 1 1 2 1 0",
                     ok, rd_q.size(), dc, dn, bad);
        end else begin
            checks++;
            if (rd_q[0] !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL single_rdata: got %h expected deadbeef", rd_q[0]);
            end
        end
    endtask

    task automatic test_wrap_write();
        int ok, dc, dn, bad, last;
        logic [7:0] a;
        for (int i = 0; i < 4; i++) wdata[i] = 32'(i + 1);
        issue(1, 8'hFE, 4, ok);
        run_write(8'hFE, 4, 1, dc, dn, bad, last);
        checks++;
        if (ok != 1 || bad != 0 || last != 7 || dc != 8 || dn != 1) begin
            errors++;
            $display("FAIL wrap_write: ok %0d bad %0d last_beat %0d done_cyc %0d done_cnt %0d expected 1 0 7 8 1",
                     ok, bad, last, dc, dn);
        end
        for (int i = 0; i < 4; i++) begin
            a = 8'(8'hFE + i);
            checks++;
            if (mem[a] !== 32'(i + 1)) begin
                errors++;
                $display("FAIL wrap_mem[%h]: got %h expected %h", a, mem[a], 32'(i + 1));
            end
        end
    endtask

    task automatic test_read_backpressure();
        int ok, dc, dn, bad, last;
        for (int i = 0; i < 16; i++) preload(8'(i), 32'(i * 3));
        issue(0, 8'h00, 16, ok);
        run_read(8'h00, 16, 1, dc, dn, bad, last);
        checks++;
        if (ok != 1 || bad != 0 || dc != 49 || dc != last || dn != 1 || rd_q.size() != 16) begin
            errors++;
            $display("FAIL bp_read: ok %0d bad %0d done_cyc %0d last %0d done_cnt %0d beats %0d expected 1 0 49 49 1 16",
                     ok, bad, dc, last, dn, rd_q.size());
        end
        for (int i = 0; i < rd_q.size(); i++) begin
            checks++;
            if (rd_q[i] !== 32'(i * 3)) begin
                errors++;
                $display("FAIL bp_beat%0d: got %h expected %h", i, rd_q[i], 32'(i * 3));
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int ok;
        logic [7:0]  a;
        logic [31:0] old2, old3;
        a = 8'($urandom);
        for (int i = 0; i < 4; i++) wdata[i] = $urandom;
        old2 = ref_mem[8'(a + 2)];
        old3 = ref_mem[8'(a + 3)];
        issue(1, a, 4, ok);
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1; wr_data = wdata[i];
            tick();
        end
        wr_valid = 1; wr_data = wdata[2];
        checks++;
        if (ok != 1 || ram_cs !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: ok %0d ram_cs %b expected 1 1", ok, ram_cs);
        end
        #1 rst = 1;
        #1;
        checks++;
        if (ram_cs !== 1'b0 || req_ready !== 1'b1 || rd_valid !== 1'b0 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_immediate: cs %b req_ready %b rd_valid %b wr_ready %b expected 0 1 0 0",
                     ram_cs, req_ready, rd_valid, wr_ready);
        end
        @(negedge clk);
        #1;
        ref_mem[a] = wdata[0];
        ref_mem[8'(a + 1)] = wdata[1];
        checks++;
        if (mem[a] !== wdata[0] || mem[8'(a + 1)] !== wdata[1]) begin
            errors++;
            $display("FAIL rst_written: got %h %h expected %h %h", mem[a], mem[8'(a + 1)], wdata[0], wdata[1]);
        end
        checks++;
        if (mem[8'(a + 2)] !== old2 || mem[8'(a + 3)] !== old3) begin
            errors++;
            $display("FAIL rst_unwritten: got %h %h expected %h %h", mem[8'(a + 2)], mem[8'(a + 3)], old2, old3);
        end
        wr_valid = 0;
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_busy();
        int dc, rc, nb, nbad, dc2, dn2, bad2, last2;
        logic [7:0] x, y;
        dc = 0; rc = 0; nb = 0; nbad = 0;
        x = 8'($urandom);
        y = 8'($urandom);
        req_valid = 1; req_write = 0; req_addr = x; req_len = 4'd3; rd_ready = 1;
        @(negedge clk);
        tick();
        req_addr = y; req_len = 4'd0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                if (rd_data !== ref_mem[8'(x + nb)]) nbad++;
                nb++;
            end
            if (done === 1'b1 && dc == 0) dc = c;
            if (req_ready === 1'b1 && rc == 0) rc = c;
            tick();
            if (rc != 0) break;
        end
        req_valid = 0;
        checks++;
        if (dc != 5 || rc != 6 || nb != 4 || nbad != 0) begin
            errors++;
            $display("FAIL busy_hold: done_cyc %0d ready_cyc %0d beats %0d bad_data %0d expected 5 6 4 0",
                     dc, rc, nb, nbad);
        end
        run_read(y, 1, 0, dc2, dn2, bad2, last2);
        checks++;
        if (rd_q.size() != 1 || bad2 != 0 || dc2 != 2 || dn2 != 1) begin
            errors++;
            $display("FAIL busy_second: beats %0d bad %0d done_cyc %0d done_cnt %0d expected 1 0 2 1",
                     rd_q.size(), bad2, dc2, dn2);
        end else begin
            checks++;
            if (rd_q[0] !== ref_mem[y]) begin
                errors++;
                $display("FAIL busy_second_data: got %h expected %h", rd_q[0], ref_mem[y]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ok1, ok2, dc1, dn1, dc2, dn2, bad1, bad2, l1, l2;
        logic [7:0] a;
        a = 8'($urandom);
        wdata[0] = $urandom;
        issue(1, a, 1, ok1);
        run_write(a, 1, 0, dc1, dn1, bad1, l1);
        issue(0, a, 1, ok2);
        run_read(a, 1, 0, dc2, dn2, bad2, l2);
        checks++;
        if (ok1 != 1 || ok2 != 1 || dn1 != 1 || dn2 != 1 || dc1 != 2 || dc2 != 2 || bad1 != 0 || bad2 != 0) begin
            errors++;
            $display("FAIL b2b_flow: ok %0d %0d done_cnt %0d %0d done_cyc %0d %0d bad %0d %0d expected 1 1 1 1 2 2 0 0",
                     ok1, ok2, dn1, dn2, dc1, dc2, bad1, bad2);
        end
        checks++;
        if (rd_q.size() != 1 || rd_q[0] !== wdata[0]) begin
            errors++;
            $display("FAIL b2b_data: beats %0d got %h expected %h", rd_q.size(),
                     (rd_q.size() > 0) ? rd_q[0] : 32'h0, wdata[0]);
        end
    endtask

    task automatic test_random();
        int ok, dc, dn, bad, last, n, nbad;
        logic w;
        logic [7:0] a;
        logic [31:0] expq [$];
        for (int it = 0; it < 12; it++) begin
            w = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            n = $urandom_range(1, 16);
            if (w) begin
                for (int i = 0; i < 16; i++) wdata[i] = $urandom;
                issue(1, a, n, ok);
                run_write(a, n, 2, dc, dn, bad, last);
                nbad = 0;
                for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nbad++;
                checks++;
                if (ok != 1 || bad != 0 || dn != 1 || dc != last + 1 || nbad != 0) begin
                    errors++;
                    $display("FAIL rand_write%0d: ok %0d bad %0d done_cnt %0d done_cyc %0d last %0d mem_diff %0d expected 1 0 1 last+1 0",
                             it, ok, bad, dn, dc, last, nbad);
                end
            end else begin
                expq.delete();
                for (int i = 0; i < n; i++) expq.push_back(ref_mem[8'(a + i)]);
                issue(0, a, n, ok);
                run_read(a, n, 2, dc, dn, bad, last);
                nbad = 0;
                if (rd_q.size() != n) nbad = 99;
                else for (int i = 0; i < n; i++) if (rd_q[i] !== expq[i]) nbad++;
                checks++;
                if (ok != 1 || bad != 0 || dn != 1 || dc != last || nbad != 0) begin
                    errors++;
                    $display("FAIL rand_read%0d: ok %0d bad %0d done_cnt %0d done_cyc %0d last %0d data_diff %0d expected 1 0 1 last 0",
                             it, ok, bad, dn, dc, last, nbad);
                end
            end
        end
    endtask

    initial begin
        rst = 1;
        req_valid = 0; req_write = 0; req_addr = '0; req_len = '0;
        wr_valid = 0; wr_data = '0; rd_ready = 0;
        load_en = 0; load_addr = '0; load_data = '0;
        for (int i = 0; i < 16; i++) wdata[i] = '0;
        #1;
        for (int i = 0; i < 256; i++) preload(8'(i), $urandom);
        test_reset();
        rst = 0;
        tick();
        test_single();
        test_wrap_write();
        test_read_backpressure();
        test_reset_mid_write();
        test_reset();
        test_busy();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
